// File: rtl/ascon_serial_loader_pkg.sv
// Shared widths and FSM encoding for the Ascon serial operand loader.
`timescale 1ns/1ps
package ascon_serial_loader_pkg;

  localparam int unsigned K = 128;
  localparam int unsigned N = 128;
  localparam int unsigned L = 32;
  localparam int unsigned Y = 32;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAXW = maxOf(maxOf(K, N), maxOf(L, Y));
  localparam int unsigned CNTW = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    START = 3'd4,
    WAIT  = 3'd5
  } state_t;

endpackage

// File: rtl/ascon_serial_loader_if.sv
// Operand load handshake plus serial/core-control bus of the serial loader.
`timescale 1ns/1ps
interface ascon_serial_loader_if #(
  parameter int unsigned K = ascon_serial_loader_pkg::K,
  parameter int unsigned N = ascon_serial_loader_pkg::N,
  parameter int unsigned L = ascon_serial_loader_pkg::L,
  parameter int unsigned Y = ascon_serial_loader_pkg::Y
);
  logic [K-1:0] key_i;
  logic [N-1:0] nonce_i;
  logic [L-1:0] ad_i;
  logic [Y-1:0] pt_i;
  logic         load_valid_i;
  logic         load_ready_o;
  logic         core_rst_o;
  logic         key_bit_o;
  logic         nonce_bit_o;
  logic         ad_bit_o;
  logic         pt_bit_o;
  logic         enc_start_o;
  logic         enc_ready_i;
  logic         busy_o;

  // Environment side: supplies operands and core status.
  modport master (
    output key_i, nonce_i, ad_i, pt_i, load_valid_i, enc_ready_i,
    input  load_ready_o, core_rst_o, key_bit_o, nonce_bit_o, ad_bit_o, pt_bit_o,
           enc_start_o, busy_o
  );

  // Loader side.
  modport slave (
    input  key_i, nonce_i, ad_i, pt_i, load_valid_i, enc_ready_i,
    output load_ready_o, core_rst_o, key_bit_o, nonce_bit_o, ad_bit_o, pt_bit_o,
           enc_start_o, busy_o
  );
endinterface

// File: rtl/ascon_serial_loader_piso.sv
// Parallel-in serial-out register: MSB out, shifts left with zero fill.
`timescale 1ns/1ps
module ascon_piso #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shiftEn,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst)          sr <= '0;
    else if (load)    sr <= din;
    else if (shiftEn) sr <= sr << 1;
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/ascon_serial_loader.sv
// Captures a key/nonce/AD/PT set, clears the core, streams operands MSB first, then requests encryption.
`timescale 1ns/1ps
module ascon_serial_loader
  import ascon_serial_loader_pkg::*;
#(
  parameter int unsigned K = ascon_serial_loader_pkg::K,
  parameter int unsigned N = ascon_serial_loader_pkg::N,
  parameter int unsigned L = ascon_serial_loader_pkg::L,
  parameter int unsigned Y = ascon_serial_loader_pkg::Y
) (
  input logic                 clk,
  input logic                 rst,
  ascon_serial_loader_if.slave bus
);

  localparam int unsigned maxW = maxOf(maxOf(K, N), maxOf(L, Y));
  localparam int unsigned cntW = $clog2(maxW + 1);
  localparam logic [cntW-1:0] lastCnt = cntW'(maxW - 1);

  state_t          state, stateNext;
  logic [cntW-1:0] cnt;
  logic            loadFire;
  logic            shiftEn;
  logic            keyMsb, nonceMsb, adMsb, ptMsb;

  assign loadFire = (state == IDLE) && bus.load_valid_i;
  assign shiftEn  = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Saturates at the last SHIFT index; only a new load clears it.
  always_ff @(posedge clk) begin
    if (rst)                         cnt <= '0;
    else if (loadFire)               cnt <= '0;
    else if (shiftEn && cnt != lastCnt) cnt <= cnt + cntW'(1);
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (bus.load_valid_i) stateNext = CLR;
      CLR:   stateNext = SHIFT;
      SHIFT: if (cnt == lastCnt) stateNext = GAP;
      GAP:   stateNext = START;
      START: if (bus.enc_ready_i) stateNext = WAIT;
      // Ready-low and one-cycle-elapsed coincide, so WAIT always lasts one cycle.
      WAIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready_o = 1'b0;
    bus.core_rst_o   = 1'b0;
    bus.enc_start_o  = 1'b0;
    bus.key_bit_o    = 1'b0;
    bus.nonce_bit_o  = 1'b0;
    bus.ad_bit_o     = 1'b0;
    bus.pt_bit_o     = 1'b0;
    bus.busy_o       = (state != IDLE);
    unique case (state)
      IDLE:  bus.load_ready_o = 1'b1;
      CLR:   bus.core_rst_o   = 1'b1;
      SHIFT: begin
        bus.key_bit_o   = keyMsb;
        bus.nonce_bit_o = nonceMsb;
        bus.ad_bit_o    = adMsb;
        bus.pt_bit_o    = ptMsb;
      end
      START: bus.enc_start_o  = 1'b1;
      default: ;
    endcase
  end

  ascon_piso #(.W(K)) uKey (
    .clk(clk), .rst(rst), .load(loadFire), .shiftEn(shiftEn), .din(bus.key_i), .msb(keyMsb)
  );
  ascon_piso #(.W(N)) uNonce (
    .clk(clk), .rst(rst), .load(loadFire), .shiftEn(shiftEn), .din(bus.nonce_i), .msb(nonceMsb)
  );
  ascon_piso #(.W(L)) uAd (
    .clk(clk), .rst(rst), .load(loadFire), .shiftEn(shiftEn), .din(bus.ad_i), .msb(adMsb)
  );
  ascon_piso #(.W(Y)) uPt (
    .clk(clk), .rst(rst), .load(loadFire), .shiftEn(shiftEn), .din(bus.pt_i), .msb(ptMsb)
  );

endmodule

// File: tb/tb_ascon_serial_loader.sv
// Directed bench for ascon_serial_loader: reset, streaming, start handshake, abort, back-to-back.
`timescale 1ns/1ps
module tb_ascon_serial_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_serial_loader_if bus ();

  ascon_serial_loader dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // {load_ready, busy, core_rst, enc_start, key_bit, nonce_bit, ad_bit, pt_bit}
  logic [7:0] stat;
  always_comb stat = {bus.load_ready_o, bus.busy_o, bus.core_rst_o, bus.enc_start_o,
                      bus.key_bit_o, bus.nonce_bit_o, bus.ad_bit_o, bus.pt_bit_o};

  localparam logic [7:0] ST_IDLE  = 8'b1000_0000;
  localparam logic [7:0] ST_CLR   = 8'b0110_0000;
  localparam logic [7:0] ST_GAP   = 8'b0100_0000;
  localparam logic [7:0] ST_START = 8'b0101_0000;
  localparam logic [7:0] ST_WAIT  = 8'b0100_0000;

  localparam logic [127:0] KEY_A   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NONCE_A = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [31:0]  AD_A    = 32'hA5A5A5A5;
  localparam logic [31:0]  PT_A    = 32'hDEADBEEF;

  localparam logic [127:0] KEY_B   = 128'h8000000000000000FEDCBA9876543211;
  localparam logic [127:0] NONCE_B = 128'h0123456789ABCDEF0F1E2D3C4B5A6978;
  localparam logic [31:0]  AD_B    = 32'h00000001;
  localparam logic [31:0]  PT_B    = 32'h80000000;

  localparam logic [127:0] KEY_C   = 128'hCAFEBABE0123456789ABCDEFFFFFFFFF;
  localparam logic [127:0] NONCE_C = 128'hFFFFFFFF000000005555AAAA3333CCCC;
  localparam logic [31:0]  AD_C    = 32'h12345678;
  localparam logic [31:0]  PT_C    = 32'h0F0F00F0;

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents an operand set from an IDLE negedge; returns 1ns after the accepting edge.
  task automatic doLoad(input logic [127:0] k, input logic [127:0] n,
                        input logic [31:0] a, input logic [31:0] p, input bit hold);
    bus.key_i = k; bus.nonce_i = n; bus.ad_i = a; bus.pt_i = p;
    bus.load_valid_i = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.load_valid_i = 1'b0;
  endtask

  // Samples CLR, 128 SHIFT cycles and GAP; returns at the first START negedge.
  task automatic captureStream(input string tag, input logic [127:0] ek, input logic [127:0] en,
                               input logic [31:0] ea, input logic [31:0] ep, input bit scramble);
    logic [127:0] kc, nc;
    logic [31:0]  ac, pc;
    logic         tail;
    int           zero;
    bit           seen;
    kc = '0; nc = '0; ac = '0; pc = '0; tail = 1'b0; zero = 0; seen = 1'b0;
    @(negedge clk);
    checkVal({tag, "_clr"}, 128'(stat), 128'(ST_CLR));
    if (!bus.enc_start_o) zero++;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      if (scramble && c == 5) begin
        bus.key_i = KEY_C; bus.nonce_i = NONCE_C; bus.ad_i = AD_C; bus.pt_i = PT_C;
      end
      kc = {kc[126:0], bus.key_bit_o};
      nc = {nc[126:0], bus.nonce_bit_o};
      if (c < 32) begin
        ac = {ac[30:0], bus.ad_bit_o};
        pc = {pc[30:0], bus.pt_bit_o};
      end else begin
        tail = tail | bus.ad_bit_o | bus.pt_bit_o;
      end
      checkVal({tag, "_shift_ctl"}, 128'(stat[7:4]), 128'(4'b0100));
      if (!bus.enc_start_o) zero++;
    end
    checkVal({tag, "_key"},   kc, ek);
    checkVal({tag, "_nonce"}, nc, en);
    checkVal({tag, "_ad"},    128'(ac), 128'(ea));
    checkVal({tag, "_pt"},    128'(pc), 128'(ep));
    checkVal({tag, "_tail_zero"}, 128'(tail), 128'(1'b0));
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) checkVal({tag, "_gap"}, 128'(stat), 128'(ST_GAP));
      if (bus.enc_start_o) seen = 1'b1;
      else zero++;
    end
    checkVal({tag, "_start_seen"}, 128'(seen), 128'(1'b1));
    checkVal({tag, "_latency"}, 128'(zero), 128'(130));
  endtask

  // From the first START negedge: hold ready low, then complete the handshake back to IDLE.
  task automatic finishStart(input string tag, input int holdCycles);
    checkVal({tag, "_start"}, 128'(stat), 128'(ST_START));
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkVal({tag, "_start_hold"}, 128'(stat), 128'(ST_START));
    end
    bus.enc_ready_i = 1'b1;
    @(negedge clk);
    checkVal({tag, "_wait"}, 128'(stat), 128'(ST_WAIT));
    bus.enc_ready_i = 1'b0;
    @(negedge clk);
    checkVal({tag, "_idle"}, 128'(stat), 128'(ST_IDLE));
  endtask

  initial begin
    bus.key_i = '0; bus.nonce_i = '0; bus.ad_i = '0; bus.pt_i = '0;
    bus.enc_ready_i = 1'b0;
    rst = 1'b1;
    bus.load_valid_i = 1'b1;          // load must lose to reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("reset_outputs", 128'(stat), 128'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.load_valid_i = 1'b0;
    @(negedge clk);
    checkVal("reset_no_load", 128'(stat), 128'(ST_IDLE));

    // Reference vector, immediate ready.
    doLoad(KEY_A, NONCE_A, AD_A, PT_A, 1'b0);
    captureStream("t1", KEY_A, NONCE_A, AD_A, PT_A, 1'b0);
    finishStart("t1", 0);

    // Boundary bits and a long stall in START.
    doLoad(KEY_B, NONCE_B, AD_B, PT_B, 1'b0);
    captureStream("t2", KEY_B, NONCE_B, AD_B, PT_B, 1'b0);
    finishStart("t2", 500);

    // Ready already high before and during streaming.
    bus.enc_ready_i = 1'b1;
    doLoad(KEY_A, NONCE_A, AD_A, PT_A, 1'b0);
    captureStream("t3", KEY_A, NONCE_A, AD_A, PT_A, 1'b0);
    finishStart("t3", 0);

    // Abort at SHIFT counter 60, then restart.
    doLoad(KEY_B, NONCE_B, AD_B, PT_B, 1'b0);
    @(negedge clk);
    repeat (60) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkVal("abort_idle", 128'(stat), 128'(ST_IDLE));
    @(negedge clk);
    checkVal("abort_no_residue", 128'(stat), 128'(ST_IDLE));
    doLoad(KEY_A, NONCE_A, AD_A, PT_A, 1'b0);
    captureStream("t4", KEY_A, NONCE_A, AD_A, PT_A, 1'b0);
    finishStart("t4", 0);

    // Valid held high: operands change mid-stream, second set taken in the IDLE after WAIT.
    doLoad(KEY_A, NONCE_A, AD_A, PT_A, 1'b1);
    captureStream("t5a", KEY_A, NONCE_A, AD_A, PT_A, 1'b1);
    finishStart("t5a", 0);
    @(posedge clk); #1;
    bus.load_valid_i = 1'b0;
    captureStream("t5b", KEY_C, NONCE_C, AD_C, PT_C, 1'b0);
    finishStart("t5b", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_serial_loader.md
ASCON_SERIAL_LOADER -- requirements
Module: ascon_serial_loader

Interface
REQ-001: Parameters SHALL be K=128 (key bits), N=128 (nonce bits), L=32 (AD bits), Y=32 (plaintext bits); MAXW = max(K,N,L,Y) is derived.
REQ-002: clk  input  1  clock; all state changes on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: key_i, nonce_i, ad_i, pt_i  input  K, N, L, Y  parallel operands, sampled only at load handshake.
REQ-005: load_valid_i  input  1  operand set available; load_ready_o  output  1  loader able to accept a set.
REQ-006: core_rst_o  output  1  one-cycle clear pulse to the downstream Ascon core, aligning its bit counters.
REQ-007: key_bit_o, nonce_bit_o, ad_bit_o, pt_bit_o  output  1 each  serial operand bits, MSB first.
REQ-008: enc_start_o  output  1  start request to core; enc_ready_i  input  1  core encryption-complete level.
REQ-009: busy_o  output  1  high in every state except IDLE.

Function
REQ-010: FSM states SHALL be IDLE, CLR, SHIFT, GAP, START, WAIT.
REQ-011: IDLE: load_ready_o=1; on load_valid_i & load_ready_o, capture all four operands into shift registers, clear bit counter, go to CLR.
REQ-012: CLR: core_rst_o=1 for exactly this one cycle; serial outputs 0; next state SHIFT.
REQ-013: SHIFT: lasts exactly MAXW cycles (counter 0..MAXW-1); in cycle c, each *_bit_o SHALL equal bit (W-1-c) of its operand while c<W, else 0.
REQ-014: Each operand register SHALL shift left by one per SHIFT cycle; serial outputs SHALL come directly from register MSBs (no extra latency).
REQ-015: After counter=MAXW-1, go to GAP: one cycle, serial outputs 0, no start asserted (lets core counter exceed MAXW).
REQ-016: START: enc_start_o=1; held high every cycle until enc_ready_i=1 is sampled, then go to WAIT.
REQ-017: WAIT: enc_start_o=0; when enc_ready_i=0 or after 1 cycle, whichever first, return to IDLE (one cycle WAIT minimum).
REQ-018: load_valid_i SHALL be ignored in every state except IDLE; operand inputs changing outside the handshake SHALL not affect outputs.
REQ-019: Counter SHALL be ceil(log2(MAXW+1)) bits and never wrap; reaching MAXW-1 is the only SHIFT exit.
REQ-020: enc_ready_i high while in IDLE..GAP SHALL be ignored.
REQ-021: Back-to-back: a load presented in the cycle of return to IDLE SHALL be accepted in that IDLE cycle.

Reset
REQ-022: rst SHALL force state IDLE, counter 0, operand registers 0, and outputs: load_ready_o=1, busy_o=0, core_rst_o=0, enc_start_o=0, all *_bit_o=0.
REQ-023: rst mid-operation (any state) SHALL abort immediately with the REQ-022 values on the next cycle; no residual core_rst_o or enc_start_o pulse.
REQ-024: rst has priority over a simultaneous load handshake (load not accepted).

Structure
REQ-025: Shared package SHALL hold the FSM state encoding and default widths K, N, L, Y and MAXW.
REQ-026: One sub-module, ascon_piso (parameterised width W, load/shift enable, MSB out, zero-fill), SHALL be instantiated four times.

Verification
REQ-027: Reset then load key=0x000102..0F, nonce=0x101112..1F, ad=0xA5A5A5A5, pt=0xDEADBEEF -> core_rst_o one cycle, then 128 key/nonce bits MSB first, ad/pt bits valid cycles 0..31 and 0 for 32..127.
REQ-028: Same load with downstream Ascon core connected -> core starts exactly in START, core reassembles key/nonce/ad/pt equal to inputs; enc_start_o drops cycle after enc_ready_i=1.
REQ-029: enc_ready_i held 0 for 500 cycles in START -> enc_start_o stays 1, busy_o=1, load_ready_o=0 throughout.
REQ-030: rst asserted at SHIFT counter=60 -> next cycle IDLE, all outputs per REQ-022; new load then restarts from CLR.
REQ-031: load_valid_i held high continuously -> second set accepted in the IDLE cycle after WAIT; operand changes during SHIFT do not alter serial stream.
REQ-032: Cycle count check: handshake to enc_start_o rising = 1 (CLR) + 128 (SHIFT) + 1 (GAP) = 130 cycles.
